// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
// Defaults assume a 100 MHz system clock.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    localparam int DEF_DEBOUNCE_CYCLES   = 1_000_000;
    localparam int DEF_LONG_PRESS_CYCLES = 100_000_000;
    localparam int DEF_SYNC_STAGES       = 2;

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// Multi-stage flip-flop synchronizer for an asynchronous level.
// All stages clear to 0 on reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw level one stage further each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer register chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer with press/release/long-press event pulses.
// A level change is accepted only after a run of stable synchronized samples.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long,
    output logic btn_held
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("btn_debounce: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_debounce: SYNC_STAGES must be >= 2");
    end

    logic sync;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (sync)
    );

    state_e              state_q, state_d;
    logic [DEB_W-1:0]    deb_q, deb_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                long_q, long_d;
    logic                held_q, held_d;
    logic                deb_done;
    logic                hold_sat;
    logic                to_idle;

    // Next-state, counter and event decode for the debounce FSM.
    always_comb begin
        state_d   = state_q;
        deb_d     = deb_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        held_d    = held_q;
        to_idle   = 1'b0;
        deb_done  = (deb_q == DEB_LAST);
        hold_sat  = (hold_q == HOLD_LAST);

        if ((state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) && !hold_sat) begin
            hold_d = hold_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (sync) begin
                    state_d = ST_PRESS_WAIT;
                    deb_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync) begin
                    state_d = ST_IDLE;
                end else if (deb_done) begin
                    state_d = ST_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sync) begin
                    state_d = ST_RELEASE_WAIT;
                    deb_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync) begin
                    state_d = ST_PRESSED;
                end else if (deb_done) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    to_idle   = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Long press fires once; a release accepted on the same edge wins.
        if ((state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) &&
            hold_sat && !held_q && !to_idle) begin
            long_d = 1'b1;
            held_d = 1'b1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            deb_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
    assign btn_held    = held_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with a run-length reference model.
// Expected outputs are queued per edge and checked by a separate monitor.
module tb_btn_debounce;

    localparam int DEB  = 8;
    localparam int LONG = 32;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, btn_press, btn_release, btn_long, btn_held;
    logic [4:0] dout;

    assign dout = {btn_level, btn_press, btn_release, btn_long, btn_held};

    btn_debounce #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG),
        .SYNC_STAGES       (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .btn_held    (btn_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [4:0] v;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int se = 0;

    int n_press = 0, n_rel = 0, n_long = 0;
    int last_press = -1, last_rel = -1, last_long = -1;

    // reference model state: input history, accepted level, run length, press age
    bit m_hist[$];
    bit m_l;
    bit m_held;
    int m_run;
    int m_age;

    task automatic chk_v(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b (level,press,release,long,held)", name, got, exp);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
        m_l    = 1'b0;
        m_held = 1'b0;
        m_run  = 0;
        m_age  = 0;
    endfunction

    // one clock edge of the reference behaviour; returns outputs after the edge
    function automatic logic [4:0] model_edge(input bit b);
        bit s;
        bit pr, rl, lg;
        pr = 1'b0;
        rl = 1'b0;
        lg = 1'b0;
        s = m_hist.pop_front();
        m_hist.push_back(b);
        if (s != m_l) m_run++;
        else m_run = 0;
        if (m_run == DEB + 1) begin
            m_l   = ~m_l;
            m_run = 0;
            if (m_l) begin
                pr    = 1'b1;
                m_age = 0;
            end else begin
                rl     = 1'b1;
                m_held = 1'b0;
            end
        end else if (m_l) begin
            if (m_age < LONG) m_age++;
            if (m_age == LONG && !m_held) begin
                lg     = 1'b1;
                m_held = 1'b1;
            end
        end
        return {m_l, pr, rl, lg, m_held};
    endfunction

    // drive one cycle of stimulus and queue the expected response
    task automatic step(input bit b, input bit r);
        exp_t e;
        bit was;
        @(negedge clk);
        btn_in = b;
        was = rst_n;
        rst_n = r;
        if (!r) begin
            if (was) begin
                #1;
                chk_v("async_reset_clear", dout, 5'b0);
            end
            model_reset();
            e.v = 5'b0;
        end else begin
            e.v = model_edge(b);
        end
        e.idx = se;
        se++;
        expq.push_back(e);
    endtask

    // monitor: compare DUT against the queued expectation after every edge
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk_v($sformatf("outputs_edge_%0d", mon_e.idx), dout, mon_e.v);
            if (btn_press) begin
                n_press++;
                last_press = mon_e.idx;
            end
            if (btn_release) begin
                n_rel++;
                last_rel = mon_e.idx;
            end
            if (btn_long) begin
                n_long++;
                last_long = mon_e.idx;
            end
        end
    end

    initial begin
        int f, p0, r0, l0;
        bit lvl;
        int len, kind;

        model_reset();
        repeat (3) step(1'b0, 1'b0);
        chk_v("reset_state", dout, 5'b0);
        repeat (4) step(1'b0, 1'b1);

        // clean press held 20 cycles
        p0 = n_press; l0 = n_long; f = se;
        repeat (20) step(1'b1, 1'b1);
        chk_i("clean_press_count", n_press - p0, 1);
        chk_i("clean_press_latency", last_press - f, SYNC + DEB);
        chk_i("clean_level_high", int'(btn_level), 1);
        chk_i("clean_no_long", n_long - l0, 0);

        r0 = n_rel; f = se;
        repeat (15) step(1'b0, 1'b1);
        chk_i("clean_release_count", n_rel - r0, 1);
        chk_i("clean_release_latency", last_rel - f, SYNC + DEB);
        chk_i("clean_level_low", int'(btn_level), 0);

        // bounce then stable press
        p0 = n_press;
        repeat (3) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        f = se;
        repeat (20) step(1'b1, 1'b1);
        chk_i("bounce_press_count", n_press - p0, 1);
        chk_i("bounce_press_latency", last_press - f, SYNC + DEB);
        repeat (15) step(1'b0, 1'b1);

        // long press
        l0 = n_long;
        repeat (50) step(1'b1, 1'b1);
        chk_i("long_count", n_long - l0, 1);
        chk_i("long_after_press", last_long - last_press, LONG);
        chk_i("held_high", int'(btn_held), 1);
        r0 = n_rel; f = se;
        repeat (15) step(1'b0, 1'b1);
        chk_i("long_release_count", n_rel - r0, 1);
        chk_i("long_release_latency", last_rel - f, SYNC + DEB);
        chk_i("held_cleared", int'(btn_held), 0);

        // short release glitch during press
        repeat (20) step(1'b1, 1'b1);
        r0 = n_rel;
        repeat (4) step(1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b1);
        chk_i("glitch_no_release", n_rel - r0, 0);
        chk_i("glitch_level_high", int'(btn_level), 1);
        repeat (15) step(1'b0, 1'b1);

        // reset mid-press, released with button still down
        repeat (20) step(1'b1, 1'b1);
        r0 = n_rel;
        repeat (3) step(1'b1, 1'b0);
        f = se;
        repeat (20) step(1'b1, 1'b1);
        chk_i("reset_no_release", n_rel - r0, 0);
        chk_i("reset_repress_latency", last_press - f, SYNC + DEB);
        repeat (15) step(1'b0, 1'b1);

        // randomized segments with occasional reset
        lvl = 1'b0;
        for (int k = 0; k < 200; k++) begin
            lvl  = ~lvl;
            kind = int'($urandom_range(0, 9));
            if (kind < 5) len = int'($urandom_range(1, DEB + 3));
            else if (kind < 8) len = int'($urandom_range(DEB, 2 * DEB));
            else len = int'($urandom_range(LONG + 5, LONG + 15));
            repeat (len) step(lvl, 1'b1);
            if ($urandom_range(0, 29) == 0) repeat (2) step(lvl, 1'b0);
        end
        repeat (15) step(1'b0, 1'b1);

        @(posedge clk);
        #2;
        chk_i("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
